// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LAT_CNT_W = 4;

  // Byte address to word index; callers truncate to their array width, which gives the wrap.
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word array with registered read and registered write; contents are not reset.
module data_mem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder: one request at a time, one-cycle ack, combinational stall.
// state | meaning: IDLE wait for request | BUSY latency countdown | RESP ack cycle
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Writedata_i,
  output logic [31:0] Readdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  state_t               state;
  logic [LAT_CNT_W-1:0] cnt;
  logic [ADDR_W-1:0]    idx_q;
  logic [ADDR_W-1:0]    idx_live;
  logic [ADDR_W-1:0]    arr_addr;
  logic [31:0]          wdata_q;
  logic [31:0]          arr_rdata;
  logic                 wr_q;
  logic                 mis_q;
  logic                 req;
  logic                 done;
  logic                 arr_we;

  assign req      = MemRead_i | MemWrite_i;
  assign stall_o  = req & ~ack_o;
  assign idx_live = ADDR_W'(word_index(Address_i));
  assign done     = (state == BUSY) && (cnt == '0);
  // Present the live index while idle so the array read is ready even with LATENCY=1.
  assign arr_addr = (state == IDLE) ? idx_live : idx_q;
  assign arr_we   = done & wr_q & ~mis_q;

  data_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(32)
  ) u_array (
    .clk  (clk_i),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      mis_q      <= 1'b0;
      Readdata_o <= '0;
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= idx_live;
            wdata_q <= Writedata_i;
            wr_q    <= MemWrite_i;
            mis_q   <= |Address_i[1:0];
            cnt     <= LAT_CNT_W'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= RESP;
            ack_o <= 1'b1;
            err_o <= mis_q;
            if (mis_q)      Readdata_o <= '0;
            else if (!wr_q) Readdata_o <= arr_rdata;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed plan items plus randomized traffic against a timeline/array model.
module tb_data_mem_responder;

  localparam int LAT   = 2;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        stall;

  data_mem_responder #(.LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .MemRead_i  (mem_read),
    .MemWrite_i (mem_write),
    .Address_i  (addr),
    .Writedata_i(wdata),
    .Readdata_o (rdata),
    .ack_o      (ack),
    .err_o      (err),
    .stall_o    (stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Model: the in-flight request, the expected read register and a shadow of the array.
  bit          m_active = 1'b0;
  int          m_acc = 0;
  bit          m_wr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] mm [DEPTH];
  bit          mk [DEPTH];
  logic [31:0] exp_rd = '0;
  bit          rd_known = 1'b1;
  int          stall_cnt = 0;
  int          last_ack_cyc = -1;
  logic        last_err = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int widx(logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  always @(negedge clk) begin
    bit e_ack, e_err, e_stall;
    e_ack   = m_active && (cyc == m_acc + LAT + 1);
    e_err   = e_ack && (m_addr[1:0] != 2'b00);
    e_stall = (mem_read | mem_write) && !e_ack;
    if (e_ack) begin
      if (e_err) begin
        exp_rd   = '0;
        rd_known = 1'b1;
      end else if (m_wr) begin
        mm[widx(m_addr)] = m_data;
        mk[widx(m_addr)] = 1'b1;
      end else begin
        exp_rd   = mm[widx(m_addr)];
        rd_known = mk[widx(m_addr)];
      end
      m_active = 1'b0;
    end
    check("ack", 32'(ack), 32'(e_ack));
    check("err", 32'(err), 32'(e_err));
    check("stall", 32'(stall), 32'(e_stall));
    if (rd_known) check("rdata", rdata, exp_rd);
    if (stall) stall_cnt++;
    if (ack) begin
      last_ack_cyc = cyc;
      last_err     = err;
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the edge ending the ack cycle.
  task automatic do_req(bit rd, bit wr, logic [31:0] a, logic [31:0] d, bit scramble);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    m_active  = 1'b1;
    m_acc     = cyc;
    m_wr      = wr;
    m_addr    = a;
    m_data    = d;
    repeat (LAT + 1) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        addr  = $urandom;
        wdata = $urandom;
      end
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    idle(3);
    check("reset_rdata", rdata, 32'h0);
    check("reset_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    idle(1);

    stall_cnt = 0;
    t0 = cyc;
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    check("store_stall_cycles", stall_cnt, 3);
    check("store_ack_offset", last_ack_cyc - t0, 3);
    check("store_err", 32'(last_err), 32'h0);

    do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("load_0x10", rdata, 32'hDEADBEEF);

    do_req(1'b0, 1'b1, 32'h11, 32'hCAFEF00D, 1'b0);
    check("misaligned_err", 32'(last_err), 32'h1);
    check("misaligned_rdata", rdata, 32'h0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("after_misaligned_load", rdata, 32'hDEADBEEF);

    do_req(1'b0, 1'b1, 32'h1000, 32'h12345678, 1'b0);
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check("wrap_load", rdata, 32'h12345678);

    do_req(1'b0, 1'b1, 32'h30, 32'hA5A50001, 1'b1);
    do_req(1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
    check("captured_inputs_load", rdata, 32'hA5A50001);

    do_req(1'b0, 1'b1, 32'h20, 32'h11112222, 1'b0);
    mem_write = 1'b1;
    addr      = 32'h20;
    wdata     = 32'h33334444;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    mem_write = 1'b0;
    exp_rd    = '0;
    rd_known  = 1'b1;
    idle(2);
    check("midreset_rdata", rdata, 32'h0);
    check("midreset_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    idle(1);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("midreset_keeps_old", rdata, 32'h11112222);
    do_req(1'b1, 1'b0, 32'h1010, 32'h0, 1'b0);
    check("wrap_alias_load", rdata, 32'hDEADBEEF);

    for (int i = 0; i < 300; i++) begin
      int          kind;
      logic [31:0] a;
      logic [31:0] low;
      kind = $urandom_range(0, 2);
      low  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0;
      a    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | low;
      do_req(kind != 1, kind != 0, a, $urandom, $urandom_range(0, 3) == 0);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipelined CPU's MEM stage. It accepts one load or store request at a time, serves it from an internal word-addressed array after a fixed, configurable latency, and returns a one-cycle acknowledge. While a request is outstanding it drives a stall to freeze the pipeline. It replaces the zero-latency data memory so the hazard and stall paths can be exercised against realistic memory timing.

## Interface
- `LATENCY`, default 2: wait cycles between request acceptance and response. Legal range 1..15.
- `ADDR_W`, default 10: word-index width. Array depth is 2^ADDR_W words.
- `clk_i` input, 1 bit: clock. All state updates on the rising edge.
- `rst_n_i` input, 1 bit: reset. Asynchronous, active-low.
- `MemRead_i` input, 1 bit: load request from EX/MEM.
- `MemWrite_i` input, 1 bit: store request from EX/MEM. If both requests are high, the store wins.
- `Address_i` input, 32 bits: byte address.
- `Writedata_i` input, 32 bits: store data.
- `Readdata_o` output, 32 bits: load data. Registered.
- `ack_o` output, 1 bit: one-cycle pulse marking request completion.
- `err_o` output, 1 bit: valid only with `ack_o`; flags a misaligned address.
- `stall_o` output, 1 bit: freeze the PC, IF/ID, ID/EX and EX/MEM registers.

## Operation
- A request is present when `MemRead_i | MemWrite_i`.
- FSM states and transitions:
  - IDLE, request present: capture address, data and the write flag; load the counter with LATENCY-1; go to BUSY.
  - BUSY, counter ≠ 0: decrement.
  - BUSY, counter = 0: go to RESP.
  - RESP: unconditionally return to IDLE.
- `stall_o = request present & ~ack_o`. It is combinational and is asserted in the IDLE cycle of acceptance, so the pipeline freezes immediately.
- Inputs are ignored outside IDLE; the captured copies are used for the whole request. The CPU holds its request stable while stalled.
- Word index = `addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo the array size.
- Store: the array is written on the edge entering RESP. `Readdata_o` is unchanged.
- Load: `Readdata_o` is loaded on the edge entering RESP and holds until the next load completes.
- Misaligned request (`addr[1:0] != 0`): `ack_o` and `err_o` are asserted, no array write occurs, and `Readdata_o` is loaded with 0.
- Reset values: FSM IDLE, counter 0, `Readdata_o` 0, `ack_o` 0, `err_o` 0. `stall_o` then follows the inputs. Array contents are not reset.
- Reset mid-request: return to IDLE with no ack. An uncommitted store is dropped.

## Timing
- A request first seen in IDLE in cycle t gives `ack_o` = 1 in cycle t+LATENCY+1. `stall_o` = 1 in cycles t..t+LATENCY.
- The pipeline advances on the edge ending the ack cycle.
- A new request presented in the cycle after ack is accepted at once; back-to-back throughput is one access per LATENCY+2 cycles.
- `ack_o` is never high for two consecutive cycles.
- `err_o` is 0 whenever `ack_o` is 0.

## Structure
- Shared package `mem_pkg`:
  - state enum {IDLE, BUSY, RESP}, 2 bits;
  - `LAT_CNT_W` = 4;
  - word-index helper function.
- Sub-module `data_mem_array`: synchronous single-port array with a write enable. Reads and writes are registered. No reset.
- This block holds the FSM, the counter, the capture registers and the error check.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10 with LATENCY=2: stall 3 cycles, ack in the 4th cycle, err 0.
- Load from 0x10: `Readdata_o` = 0xDEADBEEF in the ack cycle.
- Store to 0x11: ack with err=1. A subsequent load from 0x10 still returns 0xDEADBEEF.
- With ADDR_W=10, store 0x12345678 to 0x1000: a load from 0x0 returns 0x12345678 (wrap).
- Change `Address_i` and `Writedata_i` during BUSY: the original captured values are used.
- Assert `rst_n_i` low in the middle of a BUSY store: no ack, `Readdata_o` = 0, the location keeps its old value, and the next request completes normally.
